// File: rtl/byte_to_bcd_encoder.sv
// Sequential byte-to-BCD encoder (shift-and-add-3), one iteration per cycle.
// Eight iterations per byte; the result is published with a one-cycle done pulse.
module byte_to_bcd_encoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  bin_in,
    output logic        busy,
    output logic        done,
    output logic [11:0] bcd_out,
    output logic        o_dbg_state
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t      r_state;
    logic [19:0] r_work;
    logic [3:0]  r_cnt;

    logic [11:0] w_corr;
    logic [19:0] w_shifted;

    // 4-bit add-3 correction; nibble never carries out since input is <= 9.
    function automatic logic [3:0] adj(input logic [3:0] n);
        adj = (n >= 4'd5) ? (n + 4'd3) : n;
    endfunction

    always_comb begin
        w_corr    = {adj(r_work[19:16]), adj(r_work[15:12]), adj(r_work[11:8])};
        w_shifted = {w_corr[10:0], r_work[7:0], 1'b0};
    end

    // Handshake: start is sampled only in IDLE; busy covers the eight SHIFT
    // cycles and done pulses in the first IDLE cycle that shows the new result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_work  <= 20'h00000;
            r_cnt   <= 4'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
            bcd_out <= 12'h000;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_work  <= {12'h000, bin_in};
                        r_cnt   <= 4'd0;
                        busy    <= 1'b1;
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_work <= w_shifted;
                    r_cnt  <= r_cnt + 4'd1;
                    if (r_cnt == 4'd7) begin
                        bcd_out <= w_shifted[19:8];
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_dbg_state = (r_state == S_SHIFT);

endmodule
